// File: rtl/imem_server.sv
// imem_server: instruction memory that takes program-image writes and then answers fetch requests.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_req_valid/o_req_ready, i_req_addr   fetch request channel (byte address)
//   i_flush                discard every buffered response at the next edge
//   o_resp_valid/i_resp_ready, o_resp_data, o_resp_err   buffered response channel
//   i_ld_valid, i_ld_addr, i_ld_data      program-image write port (word index)
//   i_ld_done              leave LOAD and start serving
//   o_serving              high in SERVE
//
// Build option: define IMEM_ERR_CHECK_EN to flag misaligned or out-of-range
// requests with o_resp_err=1 and zero data; undefined, the address wraps.
module imem_server #(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [31:0]   i_req_addr,
    input  logic          i_flush,
    output logic          o_resp_valid,
    input  logic          i_resp_ready,
    output logic [31:0]   o_resp_data,
    output logic          o_resp_err,
    input  logic          i_ld_valid,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [31:0]   i_ld_data,
    input  logic          i_ld_done,
    output logic          o_serving
);
    typedef enum logic {LOAD, SERVE} state_t;

    state_t      r_state;
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_data [2];
    logic        r_err [2];
    logic [1:0]  r_count;

    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_data;
    logic          w_rd_err;
    logic          w_push;
    logic          w_pop;
    logic          w_slot;

    assign w_idx = i_req_addr[AW+1:2];

`ifdef IMEM_ERR_CHECK_EN
    assign w_rd_err = (i_req_addr[1:0] != 2'b00) || (i_req_addr[31:AW+2] != '0);
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{i_req_addr[1:0], i_req_addr[31:AW+2]};
    assign w_rd_err = 1'b0;
`endif

    // Combinational read sampled at the accept edge, so a same-cycle write
    // to the same word is not yet visible and the old contents are returned.
    assign w_rd_data = w_rd_err ? '0 : r_mem[w_idx];

    assign o_serving    = (r_state == SERVE);
    assign o_req_ready  = o_serving && (r_count != 2'd2) && !i_flush;
    assign o_resp_valid = (r_count != 2'd0);
    assign o_resp_data  = o_resp_valid ? r_data[0] : '0;
    assign o_resp_err   = o_resp_valid ? r_err[0] : 1'b0;
    assign w_push       = i_req_valid && o_req_ready;
    assign w_pop        = o_resp_valid && i_resp_ready;
    // Slot 0 is always the head; a push lands behind whatever survives the pop.
    assign w_slot       = (r_count == 2'd1) && !w_pop;

    always_ff @(posedge i_clk) begin
        if (i_ld_valid) r_mem[i_ld_addr] <= i_ld_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= LOAD;
            r_count   <= 2'd0;
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_err[0]  <= 1'b0;
            r_err[1]  <= 1'b0;
        end else begin
            if (r_state == LOAD && i_ld_done) r_state <= SERVE;
            if (i_flush) begin
                r_count <= 2'd0;
            end else begin
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
                if (w_pop) begin
                    r_data[0] <= r_data[1];
                    r_err[0]  <= r_err[1];
                end
                // Placed after the shift so a push into slot 0 wins over it.
                if (w_push) begin
                    r_data[w_slot] <= w_rd_data;
                    r_err[w_slot]  <= w_rd_err;
                end
            end
        end
    end
endmodule

// File: doc/imem_server.md
# imem_server

Instruction-memory responder serving the fetch stage. It holds the program image and answers word-fetch requests over a valid/ready request channel and a buffered valid/ready response channel. It also accepts program-image writes from a loader port. Sits between the program loader and the fetch stage; it replaces the fetch-local memory array and sits on the memory side of the fetch interface.

## Interface
- DEPTH, 1024, number of 32-bit words; power of two; AW = $clog2(DEPTH)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_addr  in  32  byte address of the instruction
- flush  in  1  fetch redirect; discards buffered responses
- resp_valid  out  1  response at head of buffer
- resp_ready  in  1  fetch consumes head response
- resp_data  out  32  instruction word
- resp_err  out  1  request was misaligned or out of range
- ld_valid  in  1  program-image write strobe
- ld_addr  in  AW  word index to write
- ld_data  in  32  word to write
- ld_done  in  1  pulse: image complete, begin serving
- serving  out  1  high in SERVE state

## Operation
- States: LOAD (after reset) and SERVE. LOAD->SERVE when ld_done=1. SERVE->LOAD only by reset. ld_done in SERVE is ignored.
- Writes: mem[ld_addr] <= ld_data on any cycle with ld_valid=1, in either state. Memory contents are not cleared by reset.
- Index: req_addr[AW+1:2].
- Response buffer: a 2-entry FIFO holding {data, err}. resp_valid = (count != 0). Head outputs resp_data and resp_err.
- req_ready = serving && count < 2 && !flush. The comb path from req_ready to resp_ready is not permitted.
- Accept (req_valid && req_ready): the word is read at that edge and pushed into the FIFO.
- Pop (resp_valid && resp_ready): the head is removed.
- Push and pop in the same cycle: count is unchanged and the order is preserved.
- flush=1: count <= 0 at the next edge, including any same-cycle pop. No push happens because req_ready is low.
- Read/write collision on the same word in the same cycle: the response carries the old contents.
- When the FIFO is empty, resp_data and resp_err hold 0.

## Timing
- Reset values: serving=0, req_ready=0, resp_valid=0, resp_data=0, resp_err=0, count=0, state=LOAD.
- Reset mid-operation clears the FIFO immediately (asynchronous). Outstanding responses are lost.
- Latency: a request accepted at edge N gives resp_valid=1 in cycle N+1.
- Throughput: with resp_ready held high, one response per cycle and count never exceeds 1.
- With resp_ready low, the FIFO fills after 2 accepts and req_ready drops in the following cycle. req_ready re-asserts in the cycle after the first pop.
- ld_done at edge N gives serving=1 and req_ready may be 1 in cycle N+1.

## Configuration
- IMEM_ERR_CHECK_EN defined:
  - req_addr[1:0]!=0 or req_addr[31:AW+2]!=0 produces an entry with resp_err=1 and resp_data=0.
  - The slot is still consumed and the latency is unchanged.
- IMEM_ERR_CHECK_EN undefined:
  - resp_err is tied to 0.
  - Low bits and high bits are ignored; the address wraps modulo DEPTH words.

## Test plan
- Reset, then write mem[0]=0x11111111 and mem[1]=0x22222222, then pulse ld_done. Request addr 0x0 then 0x4 back-to-back with resp_ready=1 -> responses 0x11111111 then 0x22222222 in consecutive cycles, resp_err=0.
- In LOAD, drive req_valid=1 -> req_ready stays 0 and no response appears until one cycle after ld_done.
- Backpressure: resp_ready=0, request 0x0, 0x4, 0x8 -> only 2 accepted and req_ready=0 on the third. Raise resp_ready -> 0x11111111 and 0x22222222 pop in order, then 0x8 is accepted.
- Flush with 2 buffered entries and resp_ready=1 -> resp_valid=0 next cycle and neither entry is delivered.
- With IMEM_ERR_CHECK_EN defined:
  - Request 0x2 -> resp_err=1, data 0.
  - Request 4*DEPTH -> resp_err=1.
- With IMEM_ERR_CHECK_EN undefined, request 4*DEPTH returns mem[0].
- Same-cycle write mem[3]=0xAAAAAAAA and request 0xC -> old value returned; a repeat request returns 0xAAAAAAAA. Assert rst low mid-stream -> resp_valid=0 immediately, and memory data survives a re-serve.
